// File: rtl/srt4_pkg.sv
// rtl/srt4_pkg.sv - shared constants and types for the radix-4 SRT divider datapath
//
// Purpose : operand/remainder widths, control-vector bit positions and the
//           quotient-digit encoding used by srt4_datapath and srt4_addsub.
// Contents: N, PW, CW, C_* control bit indices, digit_e, decode_digit().
package srt4_pkg;

    localparam int N  = 8;        // operand width
    localparam int PW = N + 3;    // remainder width: sign + 2 guard bits
    localparam int CW = 17;       // control vector width

    localparam int C_LOAD_A = 0;
    localparam int C_LOAD_B = 1;
    localparam int C_NORM   = 2;
    localparam int C_SHIFT  = 3;
    localparam int C_DP1    = 4;
    localparam int C_DN1    = 5;
    localparam int C_DN2    = 6;
    localparam int C_DP2    = 7;
    localparam int C_UPD    = 8;
    localparam int C_SUB    = 9;
    localparam int C_2B     = 10;
    localparam int C_CNT1   = 11;
    localparam int C_RSVD   = 12;
    localparam int C_QCONV  = 13;
    localparam int C_DENORM = 14;
    localparam int C_LOAD_R = 15;
    localparam int C_HOLD   = 16;

    typedef enum logic [2:0] {
        D0  = 3'd0,
        DP1 = 3'd1,
        DN1 = 3'd2,
        DP2 = 3'd3,
        DN2 = 3'd4
    } digit_e;

    // sel is ctrl[7:4]; the group should be one-hot, lowest bit wins otherwise
    function automatic digit_e decode_digit(input logic [3:0] sel);
        digit_e dig;
        dig = D0;
        if (sel[0])      dig = DP1;
        else if (sel[1]) dig = DN1;
        else if (sel[2]) dig = DN2;
        else if (sel[3]) dig = DP2;
        return dig;
    endfunction

endpackage

// File: rtl/srt4_addsub.sv
// rtl/srt4_addsub.sv - PW-bit adder/subtractor with B / 2B operand select
//
// Purpose : y = a +/- (sel_2b ? 2B : B), B zero-extended to PW bits,
//           wrapping two's complement arithmetic.
// Ports   : a      in  PW  partial remainder P
//           b      in  N   divisor register B
//           sel_2b in  1   use 2B instead of B
//           sub    in  1   1 = subtract, 0 = add
//           y      out PW  result
module srt4_addsub
    import srt4_pkg::*;
(
    input  logic [PW-1:0] a,
    input  logic [N-1:0]  b,
    input  logic          sel_2b,
    input  logic          sub,
    output logic [PW-1:0] y
);

    logic [PW-1:0] opnd;

    always_comb begin
        opnd = sel_2b ? {{(PW-N-1){1'b0}}, b, 1'b0} : {{(PW-N){1'b0}}, b};
        y    = sub ? (a - opnd) : (a + opnd);
    end

endmodule

// File: rtl/srt4_datapath.sv
// rtl/srt4_datapath.sv - radix-4 SRT divider datapath driven by a 17-bit control vector
//
// Purpose : holds P:A, B, redundant quotient QP/QN, counters cnt1/cnt2 and the
//           result registers; each asserted ctrl bit performs one register
//           action at the next rising edge. Status outputs are register taps.
// Ports   : clk, rst (sync, active-high)
//           dividend[N], divisor[N], ctrl[17]
//           b7, b[4], msbp[6], cnt1[2], p8, cnt2[3]  status to the CU
//           q_out[N], r_out[N], div0                  results
//           ctrl_err (only with SRT4_DP_CTRL_CHECK_EN) sticky control-misuse flag
// Config  : SRT4_DP_CTRL_CHECK_EN adds the ctrl_err checker and port.
module srt4_datapath
    import srt4_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  dividend,
    input  logic [N-1:0]  divisor,
    input  logic [CW-1:0] ctrl,
    output logic          b7,
    output logic [3:0]    b,
    output logic [5:0]    msbp,
    output logic [1:0]    cnt1,
    output logic          p8,
    output logic [2:0]    cnt2,
    output logic [N-1:0]  q_out,
    output logic [N-1:0]  r_out,
    output logic          div0
`ifdef SRT4_DP_CTRL_CHECK_EN
    ,
    output logic          ctrl_err
`endif
);

    logic [PW-1:0] p_q, p_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  qp_q, qp_d;
    logic [N-1:0]  qn_q, qn_d;
    logic [1:0]    cnt1_q, cnt1_d;
    logic [2:0]    cnt2_q, cnt2_d;
    digit_e        d_q, d_d;
    logic          corr_q, corr_d;
    logic [N-1:0]  q_out_q, q_out_d;
    logic [N-1:0]  r_out_q, r_out_d;
    logic          div0_q, div0_d;
    logic          hold_q, hold_d;

    digit_e        dig_new;
    logic          as_sub, as_2b;
    logic [PW-1:0] as_y;
    logic [N-1:0]  q_conv;
    logic          out_wr_en;

    // ctrl[9]/ctrl[10] duplicate what the digit register already encodes;
    // ctrl[12] is reserved.
    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl[C_RSVD], ctrl[C_2B], ctrl[C_SUB]};

    // One adder serves both the digit update (P - d*B) and the final
    // correction (P + B, selected when the digit register is zero).
    always_comb begin
        as_sub = 1'b0;
        as_2b  = 1'b0;
        case (d_q)
            DP1:     begin as_sub = 1'b1; as_2b = 1'b0; end
            DN1:     begin as_sub = 1'b0; as_2b = 1'b0; end
            DP2:     begin as_sub = 1'b1; as_2b = 1'b1; end
            DN2:     begin as_sub = 1'b0; as_2b = 1'b1; end
            default: begin as_sub = 1'b0; as_2b = 1'b0; end
        endcase
    end

    srt4_addsub u_addsub (
        .a      (p_q),
        .b      (b_q),
        .sel_2b (as_2b),
        .sub    (as_sub),
        .y      (as_y)
    );

    // Redundant-to-binary quotient conversion, less one if corrected.
    assign q_conv = qp_q - qn_q - {{(N-1){1'b0}}, corr_q};

    assign out_wr_en = !hold_q && !ctrl[C_HOLD];

    always_comb begin
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        qp_d    = qp_q;
        qn_d    = qn_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        d_d     = d_q;
        corr_d  = corr_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        div0_d  = div0_q;
        hold_d  = hold_q;
        dig_new = decode_digit(ctrl[C_DP2:C_DP1]);

        if (ctrl[C_LOAD_B]) begin
            b_d    = divisor;
            div0_d = (divisor == '0);
        end

        if (ctrl[C_LOAD_A]) begin
            // Load starts a fresh division and overrides every other action
            // on the registers it owns.
            a_d    = dividend;
            p_d    = '0;
            qp_d   = '0;
            qn_d   = '0;
            cnt1_d = '0;
            cnt2_d = '0;
            corr_d = 1'b0;
            hold_d = 1'b0;
        end else begin
            if (ctrl[C_NORM] && !ctrl[C_LOAD_B]) begin
                b_d = b_q << 1;
            end

            // P/A have a single writer per edge: norm > shift > update > denorm
            if (ctrl[C_NORM]) begin
                {p_d, a_d} = {p_q, a_q} << 1;
            end else if (ctrl[C_SHIFT]) begin
                {p_d, a_d} = {p_q, a_q} << 2;
            end else if (ctrl[C_UPD] && !ctrl[C_QCONV]) begin
                p_d = as_y;
                if (d_q == D0) begin
                    corr_d = 1'b1;
                end
            end else if (ctrl[C_DENORM]) begin
                p_d = {p_q[PW-1], p_q[PW-1:1]};
            end

            if (ctrl[C_NORM]) begin
                cnt2_d = (cnt2_q == 3'd7) ? cnt2_q : cnt2_q + 3'd1;
            end else if (ctrl[C_DENORM]) begin
                cnt2_d = (cnt2_q == 3'd0) ? cnt2_q : cnt2_q - 3'd1;
            end

            if (ctrl[C_SHIFT]) begin
                d_d  = dig_new;
                qp_d = {qp_q[N-3:0], (dig_new == DP2), (dig_new == DP1)};
                qn_d = {qn_q[N-3:0], (dig_new == DN2), (dig_new == DN1)};
            end else if (ctrl[C_UPD] && !ctrl[C_QCONV] && (d_q != D0)) begin
                d_d = D0;
            end

            if (ctrl[C_CNT1]) begin
                cnt1_d = cnt1_q + 2'd1;
            end

            if (out_wr_en && ctrl[C_UPD] && ctrl[C_QCONV]) begin
                q_out_d = q_conv;
            end
            if (out_wr_en && ctrl[C_LOAD_R]) begin
                r_out_d = p_q[N-1:0];
            end

            if (ctrl[C_HOLD]) begin
                hold_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            qp_q    <= '0;
            qn_q    <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            d_q     <= D0;
            corr_q  <= 1'b0;
            q_out_q <= '0;
            r_out_q <= '0;
            div0_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            qp_q    <= qp_d;
            qn_q    <= qn_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            d_q     <= d_d;
            corr_q  <= corr_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            div0_q  <= div0_d;
            hold_q  <= hold_d;
        end
    end

    assign b7    = b_q[N-1];
    assign b     = b_q[N-1:N-4];
    assign msbp  = p_q[PW-1:PW-6];
    assign p8    = p_q[PW-1];
    assign cnt1  = cnt1_q;
    assign cnt2  = cnt2_q;
    assign q_out = q_out_q;
    assign r_out = r_out_q;
    assign div0  = div0_q;

`ifdef SRT4_DP_CTRL_CHECK_EN
    logic ctrl_err_q, ctrl_err_d;
    logic ce_multi, ce_orphan, ce_clash;

    always_comb begin
        ce_multi   = ($countones(ctrl[C_DP2:C_DP1]) > 1);
        ce_orphan  = (|ctrl[C_DP2:C_DP1]) && !ctrl[C_SHIFT];
        ce_clash   = ctrl[C_UPD] && ctrl[C_LOAD_A];
        ctrl_err_d = ctrl_err_q;
        if (ctrl[C_LOAD_A]) begin
            ctrl_err_d = 1'b0;
        end
        // A violation in the load cycle itself must still be flagged.
        if (ce_multi || ce_orphan || ce_clash) begin
            ctrl_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_err_q <= 1'b0;
        end else begin
            ctrl_err_q <= ctrl_err_d;
        end
    end

    assign ctrl_err = ctrl_err_q;
`else
    // Default build: no control-vector checker.
`endif

endmodule

// File: tb/tb_srt4_datapath.sv
// tb/tb_srt4_datapath.sv - directed self-checking bench for srt4_datapath
module tb_srt4_datapath;
    import srt4_pkg::*;

    logic          clk;
    logic          rst;
    logic [N-1:0]  dividend;
    logic [N-1:0]  divisor;
    logic [CW-1:0] ctrl;
    logic          b7;
    logic [3:0]    b;
    logic [5:0]    msbp;
    logic [1:0]    cnt1;
    logic          p8;
    logic [2:0]    cnt2;
    logic [N-1:0]  q_out;
    logic [N-1:0]  r_out;
    logic          div0;
`ifdef SRT4_DP_CTRL_CHECK_EN
    logic          ctrl_err;
`endif

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [CW-1:0] K_LA  = 17'd1 << C_LOAD_A;
    localparam logic [CW-1:0] K_LB  = 17'd1 << C_LOAD_B;
    localparam logic [CW-1:0] K_NRM = 17'd1 << C_NORM;
    localparam logic [CW-1:0] K_SH  = 17'd1 << C_SHIFT;
    localparam logic [CW-1:0] K_DP1 = 17'd1 << C_DP1;
    localparam logic [CW-1:0] K_DN1 = 17'd1 << C_DN1;
    localparam logic [CW-1:0] K_DN2 = 17'd1 << C_DN2;
    localparam logic [CW-1:0] K_UPD = 17'd1 << C_UPD;
    localparam logic [CW-1:0] K_SUB = 17'd1 << C_SUB;
    localparam logic [CW-1:0] K_2B  = 17'd1 << C_2B;
    localparam logic [CW-1:0] K_C1  = 17'd1 << C_CNT1;
    localparam logic [CW-1:0] K_QC  = 17'd1 << C_QCONV;
    localparam logic [CW-1:0] K_DEN = 17'd1 << C_DENORM;
    localparam logic [CW-1:0] K_LR  = 17'd1 << C_LOAD_R;
    localparam logic [CW-1:0] K_HLD = 17'd1 << C_HOLD;

    srt4_datapath dut (
        .clk      (clk),
        .rst      (rst),
        .dividend (dividend),
        .divisor  (divisor),
        .ctrl     (ctrl),
        .b7       (b7),
        .b        (b),
        .msbp     (msbp),
        .cnt1     (cnt1),
        .p8       (p8),
        .cnt2     (cnt2),
        .q_out    (q_out),
        .r_out    (r_out),
        .div0     (div0)
`ifdef SRT4_DP_CTRL_CHECK_EN
        ,
        .ctrl_err (ctrl_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input logic [CW-1:0] c);
        ctrl = c;
        @(posedge clk);
        #1;
        ctrl = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        ctrl     = '0;
        dividend = '0;
        divisor  = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        chk("rst_q_out", 32'(q_out), 0);
        chk("rst_r_out", 32'(r_out), 0);
        chk("rst_div0",  32'(div0),  0);
        chk("rst_cnt1",  32'(cnt1),  0);
        chk("rst_cnt2",  32'(cnt2),  0);
        chk("rst_b",     32'(b),     0);
        chk("rst_msbp",  32'(msbp),  0);

        // 1: 100 / 7, digits 0,+1,0,-2 -> Q=14, P=64 -> R=64>>5=2
        dividend = 8'd100; divisor = 8'd7;
        tick(K_LA | K_LB);
        chk("t1_div0", 32'(div0), 0);
        repeat (5) tick(K_NRM);
        chk("t1_cnt2_norm", 32'(cnt2), 5);
        chk("t1_b_norm",    32'(b),    14);
        chk("t1_b7_norm",   32'(b7),   1);
        tick(K_SH | K_C1);
        chk("t1_msbp_it1",  32'(msbp), 1);
        tick(K_SH | K_DP1 | K_C1);
        tick(K_UPD | K_SUB);
        chk("t1_p8_it2",    32'(p8),   1);
        chk("t1_msbp_it2",  32'(msbp), 63);
        tick(K_SH | K_C1);
        chk("t1_msbp_it3",  32'(msbp), 61);
        tick(K_SH | K_DN2 | K_C1);
        chk("t1_cnt1_wrap", 32'(cnt1), 0);
        tick(K_UPD | K_2B);
        chk("t1_p8_it4",    32'(p8),   0);
        chk("t1_msbp_it4",  32'(msbp), 2);
        tick(K_UPD | K_QC);
        chk("t1_q_out",     32'(q_out), 14);
        repeat (5) tick(K_DEN);
        chk("t1_cnt2_den",  32'(cnt2), 0);
        tick(K_LR);
        chk("t1_r_out",     32'(r_out), 2);
        tick(K_HLD);
        tick(K_DEN);
        tick(K_LR);
        tick(K_UPD | K_QC);
        chk("t1_hold_r",    32'(r_out), 2);
        chk("t1_hold_q",    32'(q_out), 14);

        // 2: 255 / 1, digits 0,0,0,-1 -> Q=-1 mod 256 = 255, P=0
        dividend = 8'd255; divisor = 8'd1;
        tick(K_LA | K_LB);
        repeat (7) tick(K_NRM);
        chk("t2_cnt2_norm", 32'(cnt2), 7);
        chk("t2_b_norm",    32'(b),    8);
        tick(K_SH | K_C1);
        tick(K_SH | K_C1);
        tick(K_SH | K_C1);
        tick(K_SH | K_DN1 | K_C1);
        tick(K_UPD);
        chk("t2_p8_final",  32'(p8), 0);
        tick(K_UPD | K_QC);
        chk("t2_q_out",     32'(q_out), 255);
        repeat (7) tick(K_DEN);
        chk("t2_cnt2_den",  32'(cnt2), 0);
        tick(K_DEN);
        chk("t2_cnt2_floor", 32'(cnt2), 0);
        tick(K_LR);
        chk("t2_r_out",     32'(r_out), 0);

        // 3: 0 / 9, all digits 0
        dividend = 8'd0; divisor = 8'd9;
        tick(K_LA | K_LB);
        repeat (4) tick(K_NRM);
        chk("t3_cnt2_norm", 32'(cnt2), 4);
        chk("t3_b_norm",    32'(b),    9);
        tick(K_SH | K_C1);
        chk("t3_p8_it1", 32'(p8), 0);
        tick(K_SH | K_C1);
        chk("t3_p8_it2", 32'(p8), 0);
        tick(K_SH | K_C1);
        chk("t3_p8_it3", 32'(p8), 0);
        tick(K_SH | K_C1);
        chk("t3_p8_it4", 32'(p8), 0);
        tick(K_UPD | K_QC);
        chk("t3_q_out",  32'(q_out), 0);
        repeat (4) tick(K_DEN);
        tick(K_LR);
        chk("t3_r_out",  32'(r_out), 0);

        // 4: 100 / 7 with digits 0,+1,0,-1 -> P=-160, corrected to 64, Q=15-1
        dividend = 8'd100; divisor = 8'd7;
        tick(K_LA | K_LB);
        repeat (5) tick(K_NRM);
        tick(K_SH | K_C1);
        tick(K_SH | K_DP1 | K_C1);
        tick(K_UPD | K_SUB);
        tick(K_SH | K_C1);
        tick(K_SH | K_DN1 | K_C1);
        tick(K_UPD);
        chk("t4_p8_neg",    32'(p8), 1);
        tick(K_UPD);
        chk("t4_p8_corr",   32'(p8),   0);
        chk("t4_msbp_corr", 32'(msbp), 2);
        tick(K_UPD | K_QC);
        chk("t4_q_out",     32'(q_out), 14);
        repeat (5) tick(K_DEN);
        tick(K_LR);
        chk("t4_r_out",     32'(r_out), 2);

        // 5: divisor 0, normalise past saturation
        dividend = 8'd5; divisor = 8'd0;
        tick(K_LA | K_LB);
        chk("t5_div0", 32'(div0), 1);
        repeat (10) tick(K_NRM);
        chk("t5_cnt2_sat", 32'(cnt2), 7);
        chk("t5_b_zero",   32'(b),    0);
        chk("t5_b7_zero",  32'(b7),   0);
        chk("t5_div0_sticky", 32'(div0), 1);

        // 6: reset in the middle of an iteration
        dividend = 8'd255;
        tick(K_LA);
        repeat (3) tick(K_NRM);
        tick(K_SH | K_DP1 | K_C1);
        tick(K_SH | K_DP1 | K_C1);
        chk("t6_cnt1_pre", 32'(cnt1), 2);
        chk("t6_cnt2_pre", 32'(cnt2), 3);
        chk("t6_msbp_pre", 32'(msbp), 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_cnt1",  32'(cnt1),  0);
        chk("t6_cnt2",  32'(cnt2),  0);
        chk("t6_msbp",  32'(msbp),  0);
        chk("t6_div0",  32'(div0),  0);
        chk("t6_q_out", 32'(q_out), 0);
        chk("t6_r_out", 32'(r_out), 0);
        tick(K_UPD | K_QC);
        chk("t6_q_clean", 32'(q_out), 0);

`ifdef SRT4_DP_CTRL_CHECK_EN
        chk("ce_clear",  32'(ctrl_err), 0);
        tick(K_SH | K_DP1 | K_DN1);
        chk("ce_multi",  32'(ctrl_err), 1);
        tick(K_C1);
        chk("ce_sticky", 32'(ctrl_err), 1);
        tick(K_LA);
        chk("ce_cleared", 32'(ctrl_err), 0);
        tick(K_DP1);
        chk("ce_orphan", 32'(ctrl_err), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
